// File: rtl/if_stage_if.sv
// IF stage bundle: hazard controls, EX redirect, imem request/response and the IF/ID register outputs.
// master = fetch stage; slave = environment (hazard unit, EX, instruction memory, decode).
interface if_stage_if #(
    parameter int XLEN = 32
);
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            FetchEmpty;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_bubbles;
`endif

    modport master (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output InstrD, PCD, PCPlus4D, ValidD, FetchEmpty
`ifdef IF_PERF_CNT_EN
        , output perf_fetched, perf_bubbles
`endif
    );

    modport slave (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  InstrD, PCD, PCPlus4D, ValidD, FetchEmpty
`ifdef IF_PERF_CNT_EN
        , input perf_fetched, perf_bubbles
`endif
    );
endinterface

// File: rtl/if_stage.sv
// RV32I fetch: owns PCF, one imem request in flight, one-word fetch buffer, IF/ID register; IF_PERF_CNT_EN adds perf counters.
// Response lands in fb, reaches IF/ID the next cycle; StallF/StallD/imem_ready hold the pipe, redirect kills the in-flight word.
module if_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            kill_q, kill_d;
    logic            fb_valid_q, fb_valid_d;
    logic [XLEN-1:0] fb_instr_q, fb_instr_d;
    logic [XLEN-1:0] fb_pc_q, fb_pc_d;
    logic [XLEN-1:0] instr_id_q, instr_id_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [XLEN-1:0] pc4_id_q, pc4_id_d;
    logic            valid_id_q, valid_id_d;

    logic id_flush;
    logic fb_consume;
    logic issue;
    logic accept;
    logic resp;

    always_comb begin
        id_flush   = bus.FlushD || bus.PCSrcE;
        fb_consume = !id_flush && !bus.StallD && fb_valid_q;
        // A full buffer only blocks issue if decode is not draining it this same cycle.
        issue      = (state_q == ST_REQ) && !bus.StallF && !outstanding_q &&
                     (!fb_valid_q || fb_consume);
        accept     = issue && bus.imem_ready;
        resp       = (state_q == ST_WAIT) && outstanding_q && bus.imem_rvalid;
    end

    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (accept) begin
                    state_d       = ST_WAIT;
                    outstanding_d = 1'b1;
                    req_pc_d      = pcf_q;
                    pcf_d         = pcf_q + PC_STEP;
                end
            end
            ST_WAIT: begin
                if (resp) begin
                    state_d       = ST_REQ;
                    outstanding_d = 1'b0;
                    kill_d        = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word returning in the redirect cycle is dropped with fb, so only a still-pending one needs killing.
        if (bus.PCSrcE) begin
            pcf_d  = bus.PCTargetE & ALIGN_MASK;
            kill_d = (outstanding_q && !resp) || accept;
        end
    end

    always_comb begin
        fb_valid_d = fb_valid_q;
        fb_instr_d = fb_instr_q;
        fb_pc_d    = fb_pc_q;
        if (fb_consume) begin
            fb_valid_d = 1'b0;
        end
        if (resp && !kill_q) begin
            fb_valid_d = 1'b1;
            fb_instr_d = bus.imem_rdata;
            fb_pc_d    = req_pc_q;
        end
        if (bus.PCSrcE) begin
            fb_valid_d = 1'b0;
        end
    end

    always_comb begin
        instr_id_d = instr_id_q;
        pc_id_d    = pc_id_q;
        pc4_id_d   = pc4_id_q;
        valid_id_d = valid_id_q;
        if (id_flush) begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
        end else if (!bus.StallD) begin
            if (fb_valid_q) begin
                instr_id_d = fb_instr_q;
                pc_id_d    = fb_pc_q;
                pc4_id_d   = fb_pc_q + PC_STEP;
                valid_id_d = 1'b1;
            end else begin
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pcf_q         <= RESET_PC & ALIGN_MASK;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
            fb_valid_q    <= 1'b0;
            fb_instr_q    <= NOP_INSTR;
            fb_pc_q       <= '0;
            instr_id_q    <= NOP_INSTR;
            pc_id_q       <= '0;
            pc4_id_q      <= '0;
            valid_id_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            fb_valid_q    <= fb_valid_d;
            fb_instr_q    <= fb_instr_d;
            fb_pc_q       <= fb_pc_d;
            instr_id_q    <= instr_id_d;
            pc_id_q       <= pc_id_d;
            pc4_id_q      <= pc4_id_d;
            valid_id_q    <= valid_id_d;
        end
    end

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = pcf_q;
    assign bus.InstrD     = instr_id_q;
    assign bus.PCD        = pc_id_q;
    assign bus.PCPlus4D   = pc4_id_q;
    assign bus.ValidD     = valid_id_q;
    assign bus.FetchEmpty = !fb_valid_q && !outstanding_q;

`ifdef IF_PERF_CNT_EN
    logic        id_bubble;
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        id_bubble      = !id_flush && !bus.StallD && !fb_valid_q;
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (fb_consume && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (id_bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: queued expected imem addresses and IF/ID loads, checked by a negedge monitor.
module tb_if_stage;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } id_t;

    logic clk = 1'b0;
    logic rst;

    if_stage_if #(.XLEN(XLEN)) bus ();

    if_stage #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          resp_lat = 1;
    logic [31:0] exp_addr[$];
    id_t         exp_id[$];
    logic        prev_stalld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = {16'hC0DE, addr[15:0]};
        endcase
    endfunction

    task automatic push_id(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
        id_t e;
        e.instr = i;
        e.pc    = p;
        e.pc4   = p4;
        exp_id.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: accepted requests and fresh IF/ID loads are compared against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_req && bus.imem_ready) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL imem_addr: unexpected request to %h", bus.imem_addr);
                end else begin
                    chk("imem_addr", bus.imem_addr, exp_addr.pop_front());
                end
            end
            if (bus.ValidD && !prev_stalld) begin
                if (exp_id.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL id_load: unexpected InstrD %h PCD %h", bus.InstrD, bus.PCD);
                end else begin
                    id_t e;
                    e = exp_id.pop_front();
                    chk("InstrD", bus.InstrD, e.instr);
                    chk("PCD", bus.PCD, e.pc);
                    chk("PCPlus4D", bus.PCPlus4D, e.pc4);
                end
            end
        end
        prev_stalld = bus.StallD;
    end

    // Memory responder: one in-order response resp_lat cycles after each accepted request.
    initial begin
        logic        acc;
        logic [31:0] a;
        logic [31:0] pend;
        int          cnt;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        cnt  = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            acc = bus.imem_req && bus.imem_ready;
            a   = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(pend);
                end
            end
            if (acc) begin
                pend = a;
                if (resp_lat <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(a);
                end else begin
                    cnt = resp_lat - 1;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk_reset_values();
        chk("rst InstrD", bus.InstrD, 32'h0000_0013);
        chk("rst ValidD", {31'd0, bus.ValidD}, 32'd0);
        chk("rst PCD", bus.PCD, 32'd0);
        chk("rst PCPlus4D", bus.PCPlus4D, 32'd0);
        chk("rst imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst FetchEmpty", {31'd0, bus.FetchEmpty}, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.StallF     = 1'b0;
        bus.StallD     = 1'b0;
        bus.FlushD     = 1'b0;
        bus.PCSrcE     = 1'b0;
        bus.PCTargetE  = '0;
        bus.imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values();

        // Basic fetch of two words from RESET_PC.
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        push_id(32'h0050_0093, 32'h0, 32'h4);
        push_id(32'h0010_0113, 32'h4, 32'h8);
        rst = 1'b0;
        repeat (4) tick();
        bus.StallF = 1'b1;
        repeat (3) tick();
        chk("drained FetchEmpty", {31'd0, bus.FetchEmpty}, 32'd1);

        // StallF+StallD with a full buffer, then release.
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        push_id(32'hC0DE_0008, 32'h8, 32'hC);
        push_id(32'hC0DE_000C, 32'hC, 32'h10);
        bus.StallF = 1'b0;
        tick();
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall imem_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall InstrD", bus.InstrD, 32'h0000_0013);
            chk("stall PCD", bus.PCD, 32'h4);
            chk("stall FetchEmpty", {31'd0, bus.FetchEmpty}, 32'd0);
        end
        bus.StallF = 1'b0;
        bus.StallD = 1'b0;
        #1;
        chk("resume imem_req", {31'd0, bus.imem_req}, 32'd1);
        tick();
        bus.StallF = 1'b1;
        repeat (4) tick();

        // Redirect while a slow request is outstanding.
        resp_lat = 3;
        exp_addr.push_back(32'h10);
        exp_addr.push_back(32'h100);
        push_id(32'hC0DE_0100, 32'h100, 32'h104);
        bus.StallF = 1'b0;
        tick();
        bus.PCSrcE    = 1'b1;
        bus.PCTargetE = 32'h0000_0103;
        tick();
        bus.PCSrcE = 1'b0;
        chk("redir InstrD", bus.InstrD, 32'h0000_0013);
        chk("redir ValidD", {31'd0, bus.ValidD}, 32'd0);
        tick();
        chk("killed wait imem_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("target imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("target imem_addr", bus.imem_addr, 32'h100);
        tick();
        bus.StallF = 1'b1;
        repeat (6) tick();
        resp_lat = 1;

        // imem_ready low for four cycles.
        exp_addr.push_back(32'h104);
        push_id(32'hC0DE_0104, 32'h104, 32'h108);
        bus.imem_ready = 1'b0;
        bus.StallF     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held imem_req", {31'd0, bus.imem_req}, 32'd1);
            chk("held imem_addr", bus.imem_addr, 32'h104);
            chk("held ValidD", {31'd0, bus.ValidD}, 32'd0);
            chk("held FetchEmpty", {31'd0, bus.FetchEmpty}, 32'd1);
        end
        bus.imem_ready = 1'b1;
        tick();
        bus.StallF = 1'b1;
        repeat (4) tick();

        // PC wrap at the top of the address space, then flush beats stall.
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0);
        push_id(32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0);
        push_id(32'h0050_0093, 32'h0, 32'h4);
        bus.PCSrcE    = 1'b1;
        bus.PCTargetE = 32'hFFFF_FFFF;
        tick();
        bus.PCSrcE = 1'b0;
        bus.StallF = 1'b0;
        repeat (3) tick();
        bus.StallF = 1'b1;
        repeat (2) tick();
        bus.StallD = 1'b1;
        tick();
        chk("hold ValidD", {31'd0, bus.ValidD}, 32'd1);
        chk("hold InstrD", bus.InstrD, 32'h0050_0093);
        bus.FlushD = 1'b1;
        tick();
        chk("flush InstrD", bus.InstrD, 32'h0000_0013);
        chk("flush ValidD", {31'd0, bus.ValidD}, 32'd0);
        chk("flush PCD", bus.PCD, 32'h0);
        chk("flush PCPlus4D", bus.PCPlus4D, 32'h4);
        bus.FlushD = 1'b0;
        bus.StallD = 1'b0;
        repeat (2) tick();

        // Reset while waiting; the late response must be ignored.
        resp_lat = 3;
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h0);
        push_id(32'h0050_0093, 32'h0, 32'h4);
        bus.StallF = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk_reset_values();
        repeat (2) tick();
        rst      = 1'b0;
        resp_lat = 1;
        tick();
        chk("post-rst imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("post-rst imem_addr", bus.imem_addr, 32'h0);
        chk("post-rst FetchEmpty", {31'd0, bus.FetchEmpty}, 32'd1);
        chk("post-rst ValidD", {31'd0, bus.ValidD}, 32'd0);
        tick();
        bus.StallF = 1'b1;
        repeat (4) tick();

        chk("addr queue drained", exp_addr.size(), 32'd0);
        chk("id queue drained", exp_id.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
